// File: rtl/sram_pattern_tester.sv
// rtl/sram_pattern_tester.sv - async SRAM pattern write/read-back tester with first-failure capture
module sram_pattern_tester #(
    parameter int pDATA_WIDTH = 16,
    parameter int pADDR_WIDTH = 20,
    parameter int pBYTE_LANES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   active,
    input  logic [1:0]             I_mode,
    input  logic [pADDR_WIDTH-1:0] I_start_addr,
    input  logic [pADDR_WIDTH-1:0] I_end_addr,
    input  logic [7:0]             I_wr_setup,
    input  logic [7:0]             I_wr_pulse,
    input  logic [7:0]             I_wr_hold,
    input  logic [7:0]             I_rd_wait,
    input  logic                   I_stop_on_fail,
    output logic                   O_busy,
    output logic                   O_pass,
    output logic                   O_fail,
    output logic [31:0]            O_test_runs,
    output logic [31:0]            O_error_count,
    output logic [pADDR_WIDTH-1:0] O_fail_addr,
    output logic [pDATA_WIDTH-1:0] O_fail_expected,
    output logic [pDATA_WIDTH-1:0] O_fail_actual,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic                   sram_oen,
    output logic [pBYTE_LANES-1:0] sram_ben,
    output logic [pADDR_WIDTH-1:0] sram_addr,
    inout  wire  [pDATA_WIDTH-1:0] sram_data
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_RD_WAIT, S_RD_CHECK, S_DONE
    } state_t;

    localparam logic [31:0] CB32 = 32'h5555_5555;
    localparam logic [pDATA_WIDTH-1:0] CB_55 = CB32[pDATA_WIDTH-1:0];
    localparam logic [pDATA_WIDTH-1:0] ONE_D = pDATA_WIDTH'(1);

    state_t state, state_next;
    logic [7:0] cnt;
    logic [1:0] cfg_mode;
    logic [pADDR_WIDTH-1:0] cfg_start, cfg_end, addr;
    logic [7:0] cfg_setup, cfg_pulse, cfg_hold, cfg_rd;
    logic cfg_stop, run_err, drive;
    logic [31:0] lfsr, lfsr_step, seed, run_idx;
    logic [pDATA_WIDTH-1:0] rd_data, expected;
    logic [32:0] walk_sum, walk_pos;
    logic phase_done, last_addr, mismatch, fail_after;

    function automatic logic [7:0] wait_len(input logic [7:0] w);
        return (w == 8'd0) ? 8'd1 : w;
    endfunction

    assign phase_done = (cnt == 8'd0);
    assign last_addr  = (addr == cfg_end);
    assign mismatch   = (rd_data != expected);
    assign fail_after = O_fail | mismatch;
    assign run_idx    = seed - 32'd1;
    // Galois right-shift form of x^32+x^22+x^2+x+1
    assign lfsr_step  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    assign walk_sum   = 33'(addr) + 33'(run_idx);
    assign walk_pos   = walk_sum % 33'(pDATA_WIDTH);

    always_comb begin
        expected = '0;
        case (cfg_mode)
            2'd0: expected = lfsr[pDATA_WIDTH-1:0];
            2'd1: expected = pDATA_WIDTH'(addr);
            2'd2: expected = (addr[0] ^ run_idx[0]) ? ~CB_55 : CB_55;
            default: expected = ONE_D << walk_pos;
        endcase
    end

    assign sram_addr = addr;
    assign sram_ben  = {pBYTE_LANES{sram_cen}};
    assign sram_data = drive ? expected : {pDATA_WIDTH{1'bz}};
    assign O_busy    = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        sram_cen   = 1'b1;
        sram_wen   = 1'b1;
        sram_oen   = 1'b1;
        drive      = 1'b0;
        case (state)
            S_WR_SETUP, S_WR_HOLD: begin sram_cen = 1'b0; drive = 1'b1; end
            S_WR_PULSE: begin sram_cen = 1'b0; sram_wen = 1'b0; drive = 1'b1; end
            S_RD_WAIT, S_RD_CHECK: begin sram_cen = 1'b0; sram_oen = 1'b0; end
            default: ;
        endcase
        if (!active) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     state_next = S_WR_SETUP;
                S_WR_SETUP: if (phase_done) state_next = S_WR_PULSE;
                S_WR_PULSE: if (phase_done) state_next = S_WR_HOLD;
                S_WR_HOLD:  if (phase_done) state_next = last_addr ? S_RD_WAIT : S_WR_SETUP;
                S_RD_WAIT:  if (phase_done) state_next = S_RD_CHECK;
                S_RD_CHECK: begin
                    if (!last_addr)                   state_next = S_RD_WAIT;
                    else if (cfg_stop && fail_after)  state_next = S_DONE;
                    else                              state_next = S_WR_SETUP;
                end
                default:    state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 8'd0;
            cfg_mode <= 2'd0; cfg_start <= '0; cfg_end <= '0; cfg_stop <= 1'b0;
            cfg_setup <= 8'd1; cfg_pulse <= 8'd1; cfg_hold <= 8'd1; cfg_rd <= 8'd1;
            addr <= '0; lfsr <= 32'd1; seed <= 32'd1; rd_data <= '0; run_err <= 1'b0;
            O_pass <= 1'b0; O_fail <= 1'b0; O_test_runs <= 32'd0; O_error_count <= 32'd0;
            O_fail_addr <= '0; O_fail_expected <= '0; O_fail_actual <= '0;
        end else begin
            // each phase counter is loaded on entry and counts down to zero
            if (state_next != state) begin
                case (state_next)
                    S_WR_SETUP: cnt <= (state == S_IDLE) ? wait_len(I_wr_setup) - 8'd1 : cfg_setup - 8'd1;
                    S_WR_PULSE: cnt <= cfg_pulse - 8'd1;
                    S_WR_HOLD:  cnt <= cfg_hold - 8'd1;
                    S_RD_WAIT:  cnt <= cfg_rd - 8'd1;
                    default:    cnt <= 8'd0;
                endcase
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end

            case (state)
                S_IDLE: begin
                    O_pass <= 1'b0;
                    O_fail <= 1'b0;
                    if (active) begin
                        cfg_mode  <= I_mode;
                        cfg_start <= I_start_addr;
                        cfg_end   <= (I_end_addr < I_start_addr) ? I_start_addr : I_end_addr;
                        cfg_stop  <= I_stop_on_fail;
                        cfg_setup <= wait_len(I_wr_setup);
                        cfg_pulse <= wait_len(I_wr_pulse);
                        cfg_hold  <= wait_len(I_wr_hold);
                        cfg_rd    <= wait_len(I_rd_wait);
                        addr      <= I_start_addr;
                        lfsr      <= seed;
                        run_err   <= 1'b0;
                    end
                end
                S_WR_HOLD: begin
                    if (active && phase_done) begin
                        if (last_addr) begin
                            addr <= cfg_start;
                            lfsr <= seed;
                        end else begin
                            addr <= addr + pADDR_WIDTH'(1);
                            lfsr <= lfsr_step;
                        end
                    end
                end
                S_RD_WAIT: if (phase_done) rd_data <= sram_data;
                S_RD_CHECK: begin
                    if (active) begin
                        if (mismatch) begin
                            if (O_error_count != 32'hFFFF_FFFF) O_error_count <= O_error_count + 32'd1;
                            if (!O_fail) begin
                                O_fail_addr     <= addr;
                                O_fail_expected <= expected;
                                O_fail_actual   <= rd_data;
                            end
                            O_fail <= 1'b1;
                        end
                        if (last_addr) begin
                            O_test_runs <= O_test_runs + 32'd1;
                            O_pass      <= !(run_err || mismatch);
                            seed        <= seed + 32'd1;
                            lfsr        <= seed + 32'd1;
                            run_err     <= 1'b0;
                            addr        <= cfg_start;
                        end else begin
                            run_err <= run_err | mismatch;
                            addr    <= addr + pADDR_WIDTH'(1);
                            lfsr    <= lfsr_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_pattern_tester.sv
// tb/tb_sram_pattern_tester.sv - directed bench for sram_pattern_tester with behavioural SRAM models
module tb_sram_pattern_tester;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, active, stop_on_fail, active8;
    logic [1:0] mode;
    logic [19:0] start_addr, end_addr;
    logic [7:0] wr_setup, wr_pulse, wr_hold, rd_wait;

    wire busy, pass, fail, sram_cen, sram_wen, sram_oen;
    wire [31:0] test_runs, error_count;
    wire [19:0] fail_addr, sram_addr;
    wire [15:0] fail_expected, fail_actual, sram_data;
    wire [1:0] sram_ben;

    wire d8_busy, d8_pass, d8_fail, d8_cen, d8_wen, d8_oen;
    wire [31:0] d8_runs, d8_errs;
    wire [19:0] d8_fail_addr, d8_addr;
    wire [7:0] d8_fexp, d8_fact, d8_data;
    wire [0:0] d8_ben;

    sram_pattern_tester #(.pDATA_WIDTH(16), .pADDR_WIDTH(20), .pBYTE_LANES(2)) u_dut (
        .clk(clk), .reset(reset), .active(active), .I_mode(mode),
        .I_start_addr(start_addr), .I_end_addr(end_addr),
        .I_wr_setup(wr_setup), .I_wr_pulse(wr_pulse), .I_wr_hold(wr_hold), .I_rd_wait(rd_wait),
        .I_stop_on_fail(stop_on_fail), .O_busy(busy), .O_pass(pass), .O_fail(fail),
        .O_test_runs(test_runs), .O_error_count(error_count), .O_fail_addr(fail_addr),
        .O_fail_expected(fail_expected), .O_fail_actual(fail_actual),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_oen(sram_oen), .sram_ben(sram_ben),
        .sram_addr(sram_addr), .sram_data(sram_data)
    );

    sram_pattern_tester #(.pDATA_WIDTH(8), .pADDR_WIDTH(20), .pBYTE_LANES(1)) u_dut8 (
        .clk(clk), .reset(reset), .active(active8), .I_mode(2'd3),
        .I_start_addr(20'd0), .I_end_addr(20'd9),
        .I_wr_setup(8'd1), .I_wr_pulse(8'd1), .I_wr_hold(8'd1), .I_rd_wait(8'd1),
        .I_stop_on_fail(1'b0), .O_busy(d8_busy), .O_pass(d8_pass), .O_fail(d8_fail),
        .O_test_runs(d8_runs), .O_error_count(d8_errs), .O_fail_addr(d8_fail_addr),
        .O_fail_expected(d8_fexp), .O_fail_actual(d8_fact),
        .sram_cen(d8_cen), .sram_wen(d8_wen), .sram_oen(d8_oen), .sram_ben(d8_ben),
        .sram_addr(d8_addr), .sram_data(d8_data)
    );

    // SRAM models: ideal storage with an optional stuck-at-0 fault on one address
    logic [15:0] mem [0:255];
    logic [7:0] mem8 [0:255];
    logic stuck_en;
    logic [19:0] stuck_addr;
    logic [15:0] stuck_mask, rd_word;
    assign rd_word = mem[sram_addr[7:0]] & ((stuck_en && sram_addr == stuck_addr) ? ~stuck_mask : 16'hFFFF);
    assign sram_data = (!sram_cen && !sram_oen) ? rd_word : 16'hzzzz;
    assign d8_data = (!d8_cen && !d8_oen) ? mem8[d8_addr[7:0]] : 8'hzz;
    always @(posedge clk) begin
        if (!sram_cen && !sram_wen) mem[sram_addr[7:0]] <= sram_data;
        if (!d8_cen && !d8_wen) mem8[d8_addr[7:0]] <= d8_data;
    end

    int cyc = 0, fall_cyc = 0;
    logic prev_wen = 1'b1, prev_oen = 1'b1, prev_cen = 1'b1, prev_w8 = 1'b1;
    logic [19:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic [7:0] w8_q[$];
    int wl_q[$], wf_q[$], of_q[$], or_q[$], cf_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!sram_wen && prev_wen) begin
            wa_q.push_back(sram_addr); wd_q.push_back(sram_data); wf_q.push_back(cyc); fall_cyc = cyc;
        end
        if (sram_wen && !prev_wen) wl_q.push_back(cyc - fall_cyc);
        if (!sram_oen && prev_oen) of_q.push_back(cyc);
        if (sram_oen && !prev_oen) or_q.push_back(cyc);
        if (!sram_cen && prev_cen) cf_q.push_back(cyc);
        if (!d8_wen && prev_w8) w8_q.push_back(d8_data);
        prev_wen = sram_wen; prev_oen = sram_oen; prev_cen = sram_cen; prev_w8 = d8_wen;
    end

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    endtask

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wl_q.delete(); wf_q.delete();
        of_q.delete(); or_q.delete(); cf_q.delete(); w8_q.delete();
    endtask

    task automatic wait_runs(input logic [31:0] n, input string tag);
        int k = 0;
        while (test_runs !== n && k < 5000) begin tick(); k++; end
        chk(tag, test_runs, n);
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [19:0] s, input logic [19:0] e,
                           input logic [7:0] su, input logic [7:0] pu, input logic [7:0] ho,
                           input logic [7:0] rw, input logic stop);
        mode = m; start_addr = s; end_addr = e;
        wr_setup = su; wr_pulse = pu; wr_hold = ho; rd_wait = rw; stop_on_fail = stop;
    endtask

    logic [7:0] exp8 [0:19];
    logic [15:0] lfsr_exp [0:3];

    initial begin
        exp8 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02,
                 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
        lfsr_exp = '{16'h0001, 16'h0003, 16'h0002, 16'h0001};
        reset = 1'b1; active = 1'b0; active8 = 1'b0; stuck_en = 1'b0;
        stuck_addr = 20'd0; stuck_mask = 16'd0;
        set_cfg(2'd0, 20'd0, 20'd0, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        do_reset();

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_runs", test_runs, 32'd0);
        chk("rst_errs", error_count, 32'd0);
        chk("rst_faddr", 32'(fail_addr), 32'd0);
        chk("rst_strobes", 32'({sram_cen, sram_wen, sram_oen, sram_ben}), 32'h1F);
        chk("rst_addr", 32'(sram_addr), 32'd0);

        // address pattern, minimal waits
        clear_logs();
        set_cfg(2'd1, 20'h10, 20'h13, 8'd1, 8'd1, 8'd1, 8'd2, 1'b0);
        active = 1'b1;
        wait_runs(32'd1, "a_runs");
        chk("a_nwrites", 32'(wa_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_addr%0d", i), 32'(wa_q[i]), 32'h10 + 32'(i));
            chk($sformatf("a_data%0d", i), 32'(wd_q[i]), 32'h10 + 32'(i));
            chk($sformatf("a_wenlen%0d", i), 32'(wl_q[i]), 32'd1);
        end
        chk("a_pass", 32'(pass), 32'd1);
        chk("a_errs", error_count, 32'd0);
        chk("a_busy", 32'(busy), 32'd1);
        active = 1'b0; tick(); tick();
        chk("a_idle_pass", 32'(pass), 32'd0);
        chk("a_idle_busy", 32'(busy), 32'd0);

        // LFSR stepping, seed 1
        do_reset(); clear_logs();
        set_cfg(2'd0, 20'h10, 20'h13, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        active = 1'b1;
        wait_runs(32'd1, "l_runs");
        for (int i = 0; i < 4; i++) chk($sformatf("l_data%0d", i), 32'(wd_q[i]), 32'(lfsr_exp[i]));
        chk("l_pass", 32'(pass), 32'd1);
        active = 1'b0; tick();

        // LFSR single-address window, bit 3 stuck: seeds 1..7 pass, seed 8 fails
        do_reset();
        set_cfg(2'd0, 20'h12, 20'h12, 8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
        stuck_en = 1'b1; stuck_addr = 20'h12; stuck_mask = 16'h0008;
        active = 1'b1; tick();
        for (int k = 0; k < 2000 && busy; k++) tick();
        chk("f_busy", 32'(busy), 32'd0);
        chk("f_fail", 32'(fail), 32'd1);
        chk("f_pass", 32'(pass), 32'd0);
        chk("f_faddr", 32'(fail_addr), 32'h12);
        chk("f_fexp", 32'(fail_expected), 32'h0008);
        chk("f_fact", 32'(fail_actual), 32'h0000);
        chk("f_runs", test_runs, 32'd8);
        chk("f_errs", error_count, 32'd1);
        tick(); tick();
        chk("f_done_cen", 32'(sram_cen), 32'd1);
        chk("f_done_runs", test_runs, 32'd8);
        active = 1'b0; tick(); tick();
        chk("f_idle_fail", 32'(fail), 32'd0);
        stuck_en = 1'b0;

        // write/read phase timing 3/4/2/5
        do_reset(); clear_logs();
        set_cfg(2'd1, 20'h20, 20'h21, 8'd3, 8'd4, 8'd2, 8'd5, 1'b0);
        active = 1'b1;
        wait_runs(32'd1, "t_runs");
        chk("t_setup", 32'(wf_q[0] - cf_q[0]), 32'd3);
        chk("t_pulse0", 32'(wl_q[0]), 32'd4);
        chk("t_pulse1", 32'(wl_q[1]), 32'd4);
        chk("t_period", 32'(wf_q[1] - wf_q[0]), 32'd9);
        chk("t_hold", 32'(of_q[0] - (wf_q[1] + 4)), 32'd2);
        chk("t_oen_low", 32'(or_q[0] - of_q[0]), 32'd12);
        chk("t_pass", 32'(pass), 32'd1);
        active = 1'b0; tick();

        // walking-one on the 8-bit instance, two runs
        active8 = 1'b1;
        for (int k = 0; k < 2000 && d8_runs !== 32'd2; k++) tick();
        chk("w_runs", d8_runs, 32'd2);
        for (int i = 0; i < 20; i++) chk($sformatf("w_data%0d", i), 32'(w8_q[i]), 32'(exp8[i]));
        chk("w_pass", 32'(d8_pass), 32'd1);
        chk("w_errs", d8_errs, 32'd0);
        chk("w_fail", 32'({d8_fail, d8_fail_addr, d8_fexp, d8_fact}), 32'd0);
        active8 = 1'b0; tick();
        chk("w_idle", 32'({d8_busy, d8_ben, d8_cen}), 32'b011);

        // abort mid-write at address 5 of the second run
        do_reset(); clear_logs();
        set_cfg(2'd1, 20'd0, 20'd9, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        active = 1'b1;
        wait_runs(32'd1, "ab_runs");
        for (int k = 0; k < 500 && !(!sram_wen && sram_addr == 20'd5); k++) tick();
        chk("ab_at5", 32'({sram_wen, sram_addr}), 32'h00005);
        active = 1'b0; tick();
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_strobes", 32'({sram_cen, sram_wen, sram_oen, sram_ben}), 32'h1F);
        chk("ab_runs", test_runs, 32'd1);
        active = 1'b1; tick();
        chk("ab_restart", 32'({sram_cen, sram_addr}), 32'h00000);
        active = 1'b0; tick();

        // inverted window -> single address 7, persistent fault, no stop
        do_reset(); clear_logs();
        set_cfg(2'd1, 20'd7, 20'd3, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        stuck_en = 1'b1; stuck_addr = 20'd7; stuck_mask = 16'h0001;
        active = 1'b1;
        wait_runs(32'd1, "s_runs1");
        chk("s_nwrites", 32'(wa_q.size()), 32'd1);
        chk("s_waddr", 32'(wa_q[0]), 32'd7);
        chk("s_errs1", error_count, 32'd1);
        chk("s_faddr", 32'(fail_addr), 32'd7);
        chk("s_fexp", 32'(fail_expected), 32'd7);
        chk("s_fact", 32'(fail_actual), 32'd6);
        chk("s_pass", 32'(pass), 32'd0);
        wait_runs(32'd3, "s_runs3");
        chk("s_errs3", error_count, 32'd3);
        chk("s_faddr3", 32'(fail_addr), 32'd7);
        chk("s_busy", 32'(busy), 32'd1);
        active = 1'b0; tick(); tick();
        chk("s_idle_fail", 32'(fail), 32'd0);
        chk("s_idle_errs", error_count, 32'd3);
        stuck_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
